// File: rtl/alarm_if.sv
// alarm_if
//   Bundles the alarm controller's operational signals.
//   key_status [1:0] code-checker verdict (OK=0, ERROR=2, NOKEY=3), foreign clock domain
//   sensor     [3:0] zone inputs, asynchronous; bit 0 = entry/exit zone, bits 1-3 = instant zones
//   tick             one-clk-wide timebase enable
//   state      [2:0] current controller state
//   armed, beep, siren  decoded status outputs
//   err_cnt    [1:0] ERROR codes accepted since the last arm or disarm
//   master: drives the inputs (keypad/sensor/timebase side)
//   slave : the controller
interface alarm_if;
    logic [1:0] key_status;
    logic [3:0] sensor;
    logic       tick;
    logic [2:0] state;
    logic       armed;
    logic       beep;
    logic       siren;
    logic [1:0] err_cnt;

    modport master (
        output key_status, sensor, tick,
        input  state, armed, beep, siren, err_cnt
    );

    modport slave (
        input  key_status, sensor, tick,
        output state, armed, beep, siren, err_cnt
    );
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller
//   Intruder-alarm sequencer: arms/disarms on accepted key verdicts, runs
//   exit, entry and siren delays from an 8-bit tick-driven down-counter, and
//   raises the alarm on instant zones, entry timeout or too many wrong codes.
//   Ports:
//     clk    system clock, all state on rising edge
//     reset  asynchronous active-low reset
//     ctl    alarm_if.slave: key_status, sensor, tick in; state, armed,
//            beep, siren, err_cnt out
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   DISARMED | idle, ignores sensors and wrong codes
//   EXIT     | exit delay running, beeping, sensors ignored
//   ARMED    | watching all zones
//   ENTRY    | entry zone tripped, entry delay running, beeping
//   ALARM    | siren on for SIREN_TICKS, then back to ARMED
module alarm_controller #(
    parameter int EXIT_TICKS  = 10,
    parameter int ENTRY_TICKS = 8,
    parameter int SIREN_TICKS = 60,
    parameter int MAX_ERRORS  = 3
) (
    input  logic    clk,
    input  logic    reset,
    alarm_if.slave  ctl
);

    localparam logic [2:0] S_DISARMED = 3'd0;
    localparam logic [2:0] S_EXIT     = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_ENTRY    = 3'd3;
    localparam logic [2:0] S_ALARM    = 3'd4;

    localparam logic [1:0] KEY_OK    = 2'd0;
    localparam logic [1:0] KEY_ERR   = 2'd2;
    localparam logic [1:0] KEY_NOKEY = 2'd3;

    localparam logic [7:0] EXIT_LOAD  = 8'(EXIT_TICKS);
    localparam logic [7:0] ENTRY_LOAD = 8'(ENTRY_TICKS);
    localparam logic [7:0] SIREN_LOAD = 8'(SIREN_TICKS);
    localparam logic [1:0] ERR_LIMIT  = 2'(MAX_ERRORS);

    logic [1:0] key_s1, key_s2, key_s3, key_acc;
    logic [3:0] sens_s1, sens_s2;
    logic [2:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] err_q, err_d, err_inc;

    logic key_new, key_ok, key_err;
    logic instant, door, expiry, err_limit;

    // A verdict counts only once it has been seen identically in two
    // consecutive synchronizer stages, which filters single-cycle glitches
    // and metastability settling on the foreign-domain bus.
    assign key_new = (key_s2 == key_s3) && (key_s3 != key_acc);
    assign key_ok  = key_new && (key_s3 == KEY_OK);
    assign key_err = key_new && (key_s3 == KEY_ERR);

    assign instant   = |sens_s2[3:1];
    assign door      = sens_s2[0];
    assign expiry    = ctl.tick && (timer_q == 8'd1);
    assign err_inc   = (err_q == 2'd3) ? err_q : err_q + 2'd1;
    assign err_limit = key_err && (err_inc == ERR_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1  <= KEY_NOKEY;
            key_s2  <= KEY_NOKEY;
            key_s3  <= KEY_NOKEY;
            key_acc <= KEY_NOKEY;
            sens_s1 <= 4'd0;
            sens_s2 <= 4'd0;
            state_q <= S_DISARMED;
            timer_q <= 8'd0;
            err_q   <= 2'd0;
        end else begin
            key_s1  <= ctl.key_status;
            key_s2  <= key_s1;
            key_s3  <= key_s2;
            if (key_new) begin
                key_acc <= key_s3;
            end
            sens_s1 <= ctl.sensor;
            sens_s2 <= sens_s1;
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        // Free-running countdown; a load in the case below overrides it.
        timer_d = (ctl.tick && (timer_q != 8'd0)) ? timer_q - 8'd1 : timer_q;

        case (state_q)
            S_DISARMED: begin
                if (key_ok) begin
                    state_d = S_EXIT;
                    timer_d = EXIT_LOAD;
                end
            end
            S_EXIT: begin
                if (key_ok) begin
                    state_d = S_DISARMED;
                    timer_d = 8'd0;
                    err_d   = 2'd0;
                end else if (expiry) begin
                    state_d = S_ARMED;
                    err_d   = 2'd0;
                end
            end
            S_ARMED, S_ENTRY: begin
                if (key_err) begin
                    err_d = err_inc;
                end
                if (key_ok) begin
                    state_d = S_DISARMED;
                    timer_d = 8'd0;
                    err_d   = 2'd0;
                end else if (instant || err_limit ||
                             ((state_q == S_ENTRY) && expiry)) begin
                    state_d = S_ALARM;
                    timer_d = SIREN_LOAD;
                end else if ((state_q == S_ARMED) && door) begin
                    state_d = S_ENTRY;
                    timer_d = ENTRY_LOAD;
                end
            end
            S_ALARM: begin
                if (key_ok) begin
                    state_d = S_DISARMED;
                    timer_d = 8'd0;
                    err_d   = 2'd0;
                end else if (expiry) begin
                    state_d = S_ARMED;
                    err_d   = 2'd0;
                end
            end
            default: begin
                state_d = S_DISARMED;
                timer_d = 8'd0;
                err_d   = 2'd0;
            end
        endcase
    end

    assign ctl.state   = state_q;
    assign ctl.armed   = (state_q == S_ARMED) || (state_q == S_ENTRY) ||
                         (state_q == S_ALARM);
    assign ctl.beep    = (state_q == S_EXIT) || (state_q == S_ENTRY);
    assign ctl.siren   = (state_q == S_ALARM);
    assign ctl.err_cnt = err_q;

endmodule
